// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the req/ack instruction-memory port and the IF/ID register.
// MIPS delay-slot redirect (no flush) plus a one-entry skid buffer for a word that returns during a stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bjNPC,
  input  logic        PCSel,
  input  logic        Stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCADD4_D,
  output logic        valid_D,
  output logic        fetch_busy
);

  typedef enum logic [0:0] {
    StFetch,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] ifid_ir_q, ifid_ir_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] bj_aligned;
  logic [31:0] npc;
  logic        take_bj;
  logic        advance;

  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    bj_aligned = bjNPC & 32'hFFFF_FFFC;
    take_bj    = PCSel & ~Stall;
    if (take_bj) begin
      npc = bj_aligned;
    end else if (redir_v_q) begin
      npc = redir_pc_q;
    end else begin
      npc = pc_plus4;
    end
    advance = ~Stall & (((state_q == StFetch) & imem_ack) | (state_q == StHold));
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    redir_v_d    = redir_v_q;
    hold_ir_d    = hold_ir_q;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          if (!Stall) begin
            ifid_ir_d    = imem_rdata;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
          end else begin
            // ID cannot take the word yet; park it and stop requesting.
            hold_ir_d = imem_rdata;
            state_d   = StHold;
          end
        end else if (!Stall) begin
          ifid_ir_d    = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end
      StHold: begin
        // A stray ack here is a protocol error and is deliberately ignored.
        if (!Stall) begin
          ifid_ir_d    = hold_ir_q;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          state_d      = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    if (advance) begin
      pc_d      = npc;
      redir_v_d = 1'b0;
    end else if (take_bj) begin
      // Branch resolved while its delay slot is still in flight: remember the target.
      redir_pc_d = bj_aligned;
      redir_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      redir_pc_q   <= 32'h0;
      redir_v_q    <= 1'b0;
      hold_ir_q    <= 32'h0;
      ifid_ir_q    <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_v_q    <= redir_v_d;
      hold_ir_q    <= hold_ir_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    imem_req   = rst_n & (state_q == StFetch);
    imem_addr  = {pc_q[31:2], 2'b00};
    fetch_busy = rst_n & ((state_q == StFetch) | (state_q == StHold));
    IR_D       = ifid_ir_q;
    PC_D       = ifid_pc_q;
    PCADD4_D   = ifid_pc4_q;
    valid_D    = ifid_valid_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected fetch addresses and IF/ID entries,
// a monitor pops and compares them as the DUT accepts acks and loads IF/ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bjNPC = 32'h0;
  logic        PCSel = 1'b0;
  logic        Stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] IR_D, PC_D, PCADD4_D;
  logic        valid_D;
  logic        fetch_busy;

  always #5 clk = ~clk;

  // Memory model returns the address as the instruction word.
  assign imem_rdata = imem_addr;

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bjNPC     (bjNPC),
    .PCSel     (PCSel),
    .Stall     (Stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .IR_D      (IR_D),
    .PC_D      (PC_D),
    .PCADD4_D  (PCADD4_D),
    .valid_D   (valid_D),
    .fetch_busy(fetch_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_bubble = 0;
  logic [31:0] exp_addr[$];
  logic [95:0] exp_ifid[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic pcs, input logic [31:0] bj,
                       input logic ack);
    rst_n    = rst;
    Stall    = st;
    PCSel    = pcs;
    bjNPC    = bj;
    imem_ack = ack;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch_ok(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_ifid.push_back({a, a, a + 32'd4});
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("reset_req", 128'(imem_req), 128'(1'b0));
    chk("reset_busy", 128'(fetch_busy), 128'(1'b0));
    tick();
  endtask

  // Monitor: pre-edge sample of the request port, post-edge sample of IF/ID.
  logic        pre_rst, pre_stall, pre_ack, pre_req;
  logic [31:0] pre_addr;
  logic [96:0] last_ifid = '0;
  logic [96:0] cur_ifid;
  logic [31:0] a_exp;
  logic [95:0] i_exp;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      pre_rst   = rst_n;
      pre_stall = Stall;
      pre_ack   = imem_ack;
      pre_req   = imem_req;
      pre_addr  = imem_addr;
      if (pre_rst && pre_req && pre_ack) begin
        if (exp_addr.size() == 0) begin
          chk("addr_unexpected", 128'(pre_addr), 128'hFFFF_FFFF_FFFF);
        end else begin
          a_exp = exp_addr.pop_front();
          chk("fetch_addr", 128'(pre_addr), 128'(a_exp));
        end
      end
      @(posedge clk);
      #1;
      cur_ifid = {IR_D, PC_D, PCADD4_D, valid_D};
      if (!pre_rst) begin
        chk("reset_ifid", 128'(cur_ifid), 128'({32'h0, 32'h0, 32'h0, 1'b0}));
      end else if (!pre_stall) begin
        if (valid_D) begin
          if (exp_ifid.size() == 0) begin
            chk("ifid_unexpected", 128'(cur_ifid), 128'h0);
          end else begin
            i_exp = exp_ifid.pop_front();
            chk("ifid_entry", 128'(cur_ifid[96:1]), 128'(i_exp));
          end
        end else begin
          chk("bubble_ir", 128'(IR_D), 128'h0);
          n_bubble++;
        end
      end else begin
        chk("ifid_held", 128'(cur_ifid), 128'(last_ifid));
      end
      last_ifid = cur_ifid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int b0;

  initial begin
    tick();

    // Zero-wait sequential fetch, then a branch taken on the delay-slot ack.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("first_req", 128'(imem_req), 128'(1'b1));
    fetch_ok(32'h3000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3004); tick();
    drive(1'b1, 1'b0, 1'b1, 32'h3100, 1'b1); fetch_ok(32'h3008); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3100); tick();

    // Late redirect: branch target captured while the delay slot waits on memory.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3000); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3004); tick();
    b0 = n_bubble;
    drive(1'b1, 1'b0, 1'b1, 32'h3200, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3008); tick();
    chk("late_redir_bubbles", 128'(n_bubble - b0), 128'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3200); tick();

    // Stall at ack: word parked in the skid buffer, released three cycles later.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3000); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); exp_addr.push_back(32'h3004); tick();
    repeat (2) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("hold_req", 128'(imem_req), 128'(1'b0));
      chk("hold_busy", 128'(fetch_busy), 128'(1'b1));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("release_req", 128'(imem_req), 128'(1'b0));
    exp_ifid.push_back({32'h3004, 32'h3004, 32'h3008});
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3008); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();

    // PC wrap and bjNPC alignment.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1); fetch_ok(32'h3000); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_ifid.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_4003, 1'b1);
    exp_addr.push_back(32'h0);
    exp_ifid.push_back({32'h0, 32'h0, 32'h4});
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h4000); tick();

    // Reset while in HOLD abandons the parked word.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3000); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); exp_addr.push_back(32'h3004); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); fetch_ok(32'h3000); tick();

    repeat (3) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    chk("addr_q_drained", 128'(exp_addr.size()), 128'd0);
    chk("ifid_q_drained", 128'(exp_ifid.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
